// File: rtl/pc_npc.sv
// -----------------------------------------------------------------------------
// pc_npc -- program counter and next-PC unit for the single-cycle MIPS datapath.
//
// The unit computes the next fetch address from the current PC and the decoded
// control/operand values, and registers it on the rising clock edge. The
// address can come from four sources: sequential, conditional branch, j/jal or
// jr. If the next address is misaligned or falls outside the instruction
// window, the update is rejected. In that case the unit raises a sticky fault
// flag and halts until reset.
//
// Parameters
//   RESET_PC  : PC after reset and base of the instruction window.
//   IM_WORDS  : window size in words; window = [RESET_PC, RESET_PC + 4*IM_WORDS).
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   en         in   PC update enable (0 holds pc, instr_cnt, pc_fault)
//   npc_sel    in   [2:0] 0 seq, 1 branch, 2 j/jal, 3 jr, 4-7 seq
//   br_type    in   [2:0] 0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez, 6-7 never
//   rs_data    in   [31:0] GPR[rs] for branch compare
//   rt_data    in   [31:0] GPR[rt] for beq/bne
//   imm16      in   [15:0] instruction bits [15:0]
//   imm26      in   [25:0] instruction bits [25:0]
//   jr_target  in   [31:0] GPR[rs] for jr
//   pc         out  [31:0] current fetch address (registered)
//   pc_plus4   out  [31:0] pc + 4, jal link value (combinational)
//   npc        out  [31:0] next PC (combinational, debug)
//   br_taken   out  branch condition true with npc_sel = 1 (combinational)
//   pc_fault   out  sticky halt flag (registered)
//   instr_cnt  out  [31:0] PC updates since reset (registered, wraps)
// -----------------------------------------------------------------------------
module pc_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  npc_sel,
    input  logic [2:0]  br_type,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc,
    output logic        br_taken,
    output logic        pc_fault,
    output logic [31:0] instr_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Window bounds are held at 33 bits so that a window ending exactly at
    // 2^32 does not wrap to zero.
    localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(IM_WORDS) << 2);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_cnt;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_rs_zero;
    logic        w_rs_neg;
    logic        w_cond;
    logic        w_br_taken;
    logic [31:0] w_npc;
    logic        w_npc_illegal;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign w_j_target  = {w_pc_plus4[31:28], imm26, 2'b00};

    // The signed compare against zero needs only the sign bit and a zero test.
    assign w_rs_zero = (rs_data == 32'd0);
    assign w_rs_neg  = rs_data[31];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        w_cond = 1'b0;
        case (br_type)
            3'd0:    w_cond = (rs_data == rt_data);
            3'd1:    w_cond = (rs_data != rt_data);
            3'd2:    w_cond = w_rs_neg | w_rs_zero;
            3'd3:    w_cond = ~w_rs_neg & ~w_rs_zero;
            3'd4:    w_cond = w_rs_neg;
            3'd5:    w_cond = ~w_rs_neg;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_br_taken = (npc_sel == 3'd1) && w_cond;

    always_comb begin
        w_npc = w_pc_plus4;
        case (npc_sel)
            3'd1:    w_npc = w_br_taken ? w_br_target : w_pc_plus4;
            3'd2:    w_npc = w_j_target;
            3'd3:    w_npc = jr_target;
            default: w_npc = w_pc_plus4;
        endcase
    end

    assign w_npc_illegal = (w_npc[1:0] != 2'b00)
                        || ({1'b0, w_npc} <  WIN_LO)
                        || ({1'b0, w_npc} >= WIN_HI);

    // Reset has priority over en. A rejected update leaves pc/instr_cnt
    // untouched and parks the machine in HALT until the next reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples the values from before the edge.
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (en) begin
                        if (w_npc_illegal) begin
                            r_fault <= 1'b1;
                            r_state <= ST_HALT;
                        end else begin
                            r_pc  <= w_npc;
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign npc       = w_npc;
    assign br_taken  = w_br_taken;
    assign pc_fault  = r_fault;
    assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_pc_npc.sv
// -----------------------------------------------------------------------------
// tb_pc_npc -- directed scoreboard bench for pc_npc.
//
// Each stimulus cycle drives inputs just after a rising edge. It then pushes
// the hand-computed values expected during that cycle: the registered state
// from the previous edge, plus the combinational outputs for the new inputs.
// A separate monitor pops one entry on every falling edge and compares it
// against the DUT.
// -----------------------------------------------------------------------------
module tb_pc_npc;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        fault;
        logic [31:0] npc;
        logic        br;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  npc_sel;
    logic [2:0]  br_type;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic        br_taken;
    logic        pc_fault;
    logic [31:0] instr_cnt;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    pc_npc dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .npc_sel   (npc_sel),
        .br_type   (br_type),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .imm16     (imm16),
        .imm26     (imm26),
        .jr_target (jr_target),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .npc       (npc),
        .br_taken  (br_taken),
        .pc_fault  (pc_fault),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".pc"},        pc,        e.pc);
            check({e.name, ".instr_cnt"}, instr_cnt, e.cnt);
            check({e.name, ".pc_fault"},  {31'd0, pc_fault}, {31'd0, e.fault});
            check({e.name, ".npc"},       npc,       e.npc);
            check({e.name, ".pc_plus4"},  pc_plus4,  e.pc + 32'd4);
            check({e.name, ".br_taken"},  {31'd0, br_taken}, {31'd0, e.br});
        end
    end

    // Drive one cycle of inputs, queue its expectation, advance past the edge.
    task automatic step(
        input string       name,
        input logic        rst,
        input logic        e_n,
        input logic [2:0]  sel,
        input logic [2:0]  brt,
        input logic [31:0] rs,
        input logic [31:0] rt,
        input logic [15:0] i16,
        input logic [25:0] i26,
        input logic [31:0] jr,
        input logic [31:0] x_pc,
        input logic [31:0] x_cnt,
        input logic        x_fault,
        input logic [31:0] x_npc,
        input logic        x_br
    );
        exp_t e;
        reset     = rst;
        en        = e_n;
        npc_sel   = sel;
        br_type   = brt;
        rs_data   = rs;
        rt_data   = rt;
        imm16     = i16;
        imm26     = i26;
        jr_target = jr;
        e.name  = name;
        e.pc    = x_pc;
        e.cnt   = x_cnt;
        e.fault = x_fault;
        e.npc   = x_npc;
        e.br    = x_br;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; npc_sel = 3'd0; br_type = 3'd0;
        rs_data = '0; rt_data = '0; imm16 = '0; imm26 = '0; jr_target = '0;
        @(posedge clk);
        #1;

        //    name        rst  en  sel   brt   rs            rt     imm16     imm26        jr            pc            cnt    flt   npc           br
        step("seq0",      0,   1,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3000,     32'd0, 0,    32'h3004,     0);
        step("seq1",      0,   1,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3004,     32'd1, 0,    32'h3008,     0);
        step("seq2",      0,   1,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3008,     32'd2, 0,    32'h300C,     0);
        step("seq3",      0,   1,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h300C,     32'd3, 0,    32'h3010,     0);
        // en = 0 for two cycles: pc and instr_cnt must hold.
        step("beq_tk",    0,   0,  3'd1, 3'd0, 32'd5,        32'd5, 16'hFFFE, 26'h0,       32'h0,        32'h3010,     32'd4, 0,    32'h300C,     1);
        step("beq_nt",    0,   0,  3'd1, 3'd0, 32'd5,        32'd6, 16'hFFFE, 26'h0,       32'h0,        32'h3010,     32'd4, 0,    32'h3014,     0);
        step("hold",      0,   1,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3010,     32'd4, 0,    32'h3014,     0);
        step("j3020",     0,   1,  3'd2, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0000C08, 32'h0,        32'h3014,     32'd5, 0,    32'h3020,     0);
        step("bltz",      0,   0,  3'd1, 3'd4, 32'h80000000, 32'd0, 16'h0004, 26'h0,       32'h0,        32'h3020,     32'd6, 0,    32'h3034,     1);
        step("bgtz0",     0,   0,  3'd1, 3'd3, 32'd0,        32'd0, 16'h0004, 26'h0,       32'h0,        32'h3020,     32'd6, 0,    32'h3024,     0);
        step("blez0",     0,   1,  3'd1, 3'd2, 32'd0,        32'd0, 16'h0004, 26'h0,       32'h0,        32'h3020,     32'd6, 0,    32'h3034,     1);
        step("bne_nt",    0,   0,  3'd1, 3'd1, 32'd1,        32'd1, 16'h0004, 26'h0,       32'h0,        32'h3034,     32'd7, 0,    32'h3038,     0);
        step("bgez0",     0,   0,  3'd1, 3'd5, 32'd0,        32'd0, 16'hFFFF, 26'h0,       32'h0,        32'h3034,     32'd7, 0,    32'h3034,     1);
        step("bgez_neg",  0,   0,  3'd1, 3'd5, 32'hFFFFFFFF, 32'd0, 16'hFFFF, 26'h0,       32'h0,        32'h3034,     32'd7, 0,    32'h3038,     0);
        step("brt6",      0,   0,  3'd1, 3'd6, 32'd0,        32'd0, 16'h0004, 26'h0,       32'h0,        32'h3034,     32'd7, 0,    32'h3038,     0);
        step("sel5",      0,   0,  3'd5, 3'd0, 32'd0,        32'd0, 16'h0004, 26'h0,       32'h3000,     32'h3034,     32'd7, 0,    32'h3038,     0);
        // Reset while en = 0.
        step("rst_en0",   1,   0,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3034,     32'd7, 0,    32'h3038,     0);
        step("jal",       0,   1,  3'd2, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0000C05, 32'h0,        32'h3000,     32'd0, 0,    32'h3014,     0);
        step("jr3004",    0,   1,  3'd3, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h3004,     32'h3014,     32'd1, 0,    32'h3004,     0);
        step("jr_mis",    0,   1,  3'd3, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h3006,     32'h3004,     32'd2, 0,    32'h3006,     0);
        step("halt_seq",  0,   1,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3004,     32'd2, 1,    32'h3008,     0);
        step("rst_halt",  1,   1,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3004,     32'd2, 1,    32'h3008,     0);
        step("jr4000",    0,   1,  3'd3, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h4000,     32'h3000,     32'd0, 0,    32'h4000,     0);
        step("halt_jr",   0,   1,  3'd3, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h3FFC,     32'h3000,     32'd0, 1,    32'h3FFC,     0);
        step("halt_en0",  0,   0,  3'd3, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h2FFC,     32'h3000,     32'd0, 1,    32'h2FFC,     0);
        step("rst2",      1,   0,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3000,     32'd0, 1,    32'h3004,     0);
        step("jr_last",   0,   1,  3'd3, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h3FFC,     32'h3000,     32'd0, 0,    32'h3FFC,     0);
        step("seq_end",   0,   1,  3'd0, 3'd0, 32'd0,        32'd0, 16'h0000, 26'h0,       32'h0,        32'h3FFC,     32'd1, 0,    32'h4000,     0);
        step("halt_beq",  0,   1,  3'd1, 3'd0, 32'd7,        32'd7, 16'h0000, 26'h0,       32'h0,        32'h3FFC,     32'd1, 1,    32'h4000,     1);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_npc.md
# pc_npc

Program-counter and next-PC unit for the single-cycle MIPS datapath. It sits directly upstream of the instruction memory and drives the byte address that the memory decodes into a word index. Each cycle it computes the next fetch address from the current PC and the decoded control and operand values: sequential, conditional branch, j/jal, or jr. It registers that address on the clock edge and halts with a sticky fault flag if the address would leave the instruction window or is misaligned.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset; base of the instruction window.
- `IM_WORDS`, default 1024: instruction window size in words. The window is [RESET_PC, RESET_PC + 4*IM_WORDS).
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `en`, input, 1: PC update enable. 0 holds the PC, the counter and the fault flag.
- `npc_sel`, input, 3: next-PC source. 0 = seq, 1 = branch, 2 = jump (j/jal), 3 = jr, 4–7 = seq.
- `br_type`, input, 3: branch kind. 0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez, 6–7 never taken.
- `rs_data`, input, 32: GPR[rs] for branch compare.
- `rt_data`, input, 32: GPR[rt] for beq/bne.
- `imm16`, input, 16: instruction bits [15:0].
- `imm26`, input, 26: instruction bits [25:0].
- `jr_target`, input, 32: GPR[rs] for jr.
- `pc`, output, 32: current fetch address; feeds the instruction-memory address input.
- `pc_plus4`, output, 32: pc + 4. This is the link value for jal (no delay slot).
- `npc`, output, 32: combinational next PC, for debug.
- `br_taken`, output, 1: the branch condition is true and `npc_sel` = 1.
- `pc_fault`, output, 1: sticky halt flag.
- `instr_cnt`, output, 32: number of PC updates since reset.

## Operation
- All arithmetic is 32-bit modulo 2^32; carries out of bit 31 are discarded.
- `pc_plus4` = pc + 4.
- Branch target = pc_plus4 + (sign_extend(imm16) << 2).
- Jump target = {pc_plus4[31:28], imm26, 2'b00}.
- jr target = `jr_target`, unmodified.
- Branch conditions:
  - beq: rs_data == rt_data.
  - bne: rs_data != rt_data.
  - blez, bgtz, bltz, bgez: compare rs_data with zero as a signed value.
- `npc`:
  - branch target when `npc_sel` = 1 and the condition is true;
  - pc_plus4 when `npc_sel` = 1 and the condition is false;
  - jump target when `npc_sel` = 2;
  - jr target when `npc_sel` = 3;
  - otherwise pc_plus4.
- `npc` is illegal if npc[1:0] != 0, npc < RESET_PC, or npc >= RESET_PC + 4*IM_WORDS.
- State machine with two states, RUN and HALT:
  - RUN with en = 1 and `npc` legal: pc <= npc, instr_cnt <= instr_cnt + 1.
  - RUN with en = 1 and `npc` illegal: pc holds, instr_cnt holds, pc_fault <= 1, go to HALT.
  - RUN with en = 0: everything holds.
  - HALT: pc, instr_cnt and pc_fault hold regardless of `en` or inputs. Only `reset` leaves HALT.
- `npc` and `br_taken` stay combinationally live in HALT.

## Timing
- Reset takes priority over `en` and the fault logic. On the edge where reset = 1: pc = RESET_PC, instr_cnt = 0, pc_fault = 0, state = RUN.
- Reset asserted mid-run or in HALT has the same effect on the next edge.
- The first post-reset fetch address is RESET_PC, visible immediately after the reset edge.
- `pc`, `pc_fault` and `instr_cnt` are registered outputs.
- `npc`, `pc_plus4` and `br_taken` are combinational from `pc` and the inputs, valid in the same cycle.
- Latency: a control decision in cycle N appears on `pc` after edge N+1.
- The fault is detected and flagged on the same edge as the rejected update; `pc` keeps the last legal address.
- `instr_cnt` wraps from FFFF_FFFF to 0 with no flag.

## Test plan
- Reset then 3 cycles with npc_sel = 0, en = 1 -> pc = 3000, 3004, 3008, 300C; instr_cnt = 3; pc_fault = 0.
- At pc = 3010: beq with rs = rt = 5, imm16 = FFFE -> npc = 300C, br_taken = 1. The same branch with rt = 6 -> npc = 3014, br_taken = 0.
- At pc = 3020: bltz with rs = 8000_0000 -> taken. bgtz with rs = 0 -> not taken. blez with rs = 0 -> taken.
- jal at pc = 3000 with imm26 = 0000C05 -> npc = 3014, pc_plus4 = 3004. jr with jr_target = 3004 -> pc = 3004 next cycle.
- jr with jr_target = 3006, then jr_target = 4000 after a fresh reset -> pc holds, pc_fault = 1, and it stays 1 across later legal inputs. reset -> pc = 3000, pc_fault = 0.
- en = 0 for 2 cycles mid-run -> pc and instr_cnt unchanged. reset asserted while en = 0 -> pc = 3000, instr_cnt = 0.
